// File: rtl/pc_unit_if.sv
// Front-end control/operand bundle between the decoder/regfile side and pc_unit.
// The decoder side drives control and operands; pc_unit returns PC/NPC and RAS status.
interface pc_unit_if #(
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic          stall;
  logic          exc_req;
  logic [31:0]   exc_vec;
  logic [2:0]    NPCOp;
  logic [25:0]   IMM;
  logic [31:0]   MY_RS;
  logic [31:0]   PC;
  logic [31:0]   NPC;
  logic [31:0]   ras_pred;
  logic [CW-1:0] ras_count;
  logic          ras_miss;

  modport master (
    output stall, exc_req, exc_vec, NPCOp, IMM, MY_RS,
    input  PC, NPC, ras_pred, ras_count, ras_miss
  );

  modport slave (
    input  stall, exc_req, exc_vec, NPCOp, IMM, MY_RS,
    output PC, NPC, ras_pred, ras_count, ras_miss
  );
endinterface

// File: rtl/pc_unit.sv
// Registered PC with next-PC select, exception redirect and a return-address stack built only with `RAS_EN.
// NPC is combinational, PC loads it one cycle later; stall holds PC and RAS, exc_req overrides stall.
module pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          RAS_DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JR     = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  logic [31:0] pc_q;
  logic [31:0] pcplus4;
  logic [31:0] br_off;
  logic [31:0] npc;

  assign pcplus4 = pc_q + 32'd4;
  assign br_off  = {{14{bus.IMM[15]}}, bus.IMM[15:0], 2'b00};

  // CALL/RET share their targets with JUMP/JR; only the RAS side effects differ.
  always_comb begin
    npc = pcplus4;
    case (bus.NPCOp)
      OP_PLUS4:         npc = pcplus4;
      OP_BRANCH:        npc = pcplus4 + br_off;
      OP_JUMP, OP_CALL: npc = {pcplus4[31:28], bus.IMM, 2'b00};
      OP_JR, OP_RET:    npc = bus.MY_RS;
      default:          npc = pcplus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (bus.exc_req) begin
      pc_q <= bus.exc_vec;
    end else if (!bus.stall) begin
      pc_q <= npc;
    end
  end

  assign bus.PC  = pc_q;
  assign bus.NPC = npc;

`ifdef RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] top_q;
  logic [PW-1:0] top_inc;
  logic [CW-1:0] cnt_q;
  logic          miss_q;
  logic          advance;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign advance = !bus.exc_req && !bus.stall;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign do_push = advance && (bus.NPCOp == OP_CALL);
  assign do_pop  = advance && (bus.NPCOp == OP_RET);
  assign top_inc = top_q + PW'(1);

  // top_q indexes the newest entry; a push into a full stack wraps onto the oldest slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q  <= '0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      miss_q <= do_pop && (empty || (ras_mem[top_q] != bus.MY_RS));
      if (do_push) begin
        ras_mem[top_inc] <= pcplus4;
        top_q            <= top_inc;
        if (!full) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (do_pop && !empty) begin
        top_q <= top_q - PW'(1);
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign bus.ras_pred  = empty ? 32'd0 : ras_mem[top_q];
  assign bus.ras_count = cnt_q;
  assign bus.ras_miss  = miss_q;
`else
  assign bus.ras_pred  = 32'd0;
  assign bus.ras_count = CW'(0);
  assign bus.ras_miss  = 1'b0;
`endif
endmodule
